// File: rtl/alu_mult_pkg.sv
// Shared definitions for the byte-serial ALU/multiplier: opcodes, command/flag
// bit positions and the controller state encoding.
package alu_mult_pkg;

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,
        OP_AND  = 3'd2,
        OP_OR   = 3'd3,
        OP_XOR  = 3'd4,
        OP_PASS = 3'd5,
        OP_SHR  = 3'd6,
        OP_SHL  = 3'd7
    } alu_op_e;

    // Command byte layout: [7] MUL, [6:4] reserved, [3] CI, [2:0] op
    localparam int CMD_MUL_BIT = 7;
    localparam int CMD_CI_BIT  = 3;
    localparam int CMD_OP_MSB  = 2;
    localparam int CMD_OP_LSB  = 0;

    // Flag byte layout: {4'b0, C, V, Z, N}
    localparam int FLAG_N = 0;
    localparam int FLAG_Z = 1;
    localparam int FLAG_V = 2;
    localparam int FLAG_C = 3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_MUL,
        ST_OUT
    } state_e;

endpackage

// File: rtl/alu_mult_serial_if.sv
// Byte bus between the pad side and the ALU/multiplier engine.
interface alu_mult_serial_if;

    logic [7:0] ABCmd_i;
    logic       LoadA_i;
    logic       LoadB_i;
    logic       LoadCmd_i;
    logic [7:0] ACC_o;
    logic       Valid_o;
    logic       Done_o;
    logic       Busy_o;

    modport master (
        output ABCmd_i, LoadA_i, LoadB_i, LoadCmd_i,
        input  ACC_o, Valid_o, Done_o, Busy_o
    );

    modport slave (
        input  ABCmd_i, LoadA_i, LoadB_i, LoadCmd_i,
        output ACC_o, Valid_o, Done_o, Busy_o
    );

endinterface

// File: rtl/mult_seq.sv
// Radix-2 shift-add multiplier: the first partial product is folded into the
// start cycle, so done pulses exactly W cycles after start.
module mult_seq #(
    parameter int W = 16
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*W-1:0] p
);

    localparam int REM_W = $clog2(W);

    logic [W-1:0]     a_q;
    logic [2*W-1:0]   p_q;
    logic [REM_W-1:0] rem_q;
    logic             busy_q;
    logic             done_q;

    // Upper half accumulates, lower half holds the multiplier bits still to consume.
    function automatic logic [2*W-1:0] mul_step(input logic [2*W-1:0] acc,
                                                input logic [W-1:0]   m);
        logic [W:0] hi;
        hi = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, m} : {(W+1){1'b0}});
        return {hi, acc[W-1:1]};
    endfunction

    // NOTE: every flop is written with <= so all registers see pre-edge values;
    // blocking assignments here would create order-dependent simulation results.
    always_ff @(posedge clk) begin
        if (!reset) begin
            a_q    <= '0;
            p_q    <= '0;
            rem_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start && !busy_q) begin
                a_q    <= a;
                p_q    <= mul_step({{W{1'b0}}, b}, a);
                rem_q  <= REM_W'(W - 1);
                busy_q <= 1'b1;
            end else if (busy_q) begin
                p_q   <= mul_step(p_q, a_q);
                rem_q <= rem_q - 1'b1;
                if (rem_q == REM_W'(1)) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign p    = p_q;

endmodule

// File: rtl/alu_mult_serial.sv
// W-bit ALU/multiplier behind an 8-bit byte bus: byte-serial operand load,
// single-cycle ALU or W-cycle multiply, byte-serial result stream.
module alu_mult_serial
    import alu_mult_pkg::*;
#(
    parameter int W = 16
) (
    input  logic             clk,
    input  logic             reset,
    alu_mult_serial_if.slave bus
);

    localparam int NB    = W / 8;
    localparam int CNT_W = $clog2(2 * NB + 1);
    localparam logic [CNT_W-1:0] LEN_ALU = CNT_W'(NB + 1);
    localparam logic [CNT_W-1:0] LEN_MUL = CNT_W'(2 * NB);

    state_e           state_q;
    logic [W-1:0]     ra_q;
    logic [W-1:0]     rb_q;
    logic [7:0]       cmd_q;
    logic [2*W-1:0]   res_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] len_q;
    logic [7:0]       acc_q;
    logic             valid_q;
    logic             done_q;
    logic             busy_q;
    logic             mul_start_q;

    logic             mul_done;
    logic [2*W-1:0]   mul_p;
    logic             unused_mul_busy;
    logic             unused_cmd_bits;

    mult_seq #(.W(W)) u_mult_seq (
        .clk   (clk),
        .reset (reset),
        .start (mul_start_q),
        .a     (ra_q),
        .b     (rb_q),
        .busy  (unused_mul_busy),
        .done  (mul_done),
        .p     (mul_p)
    );

    assign unused_cmd_bits = ^cmd_q[6:4];

    // ALU datapath, evaluated from the captured command in EXEC
    alu_op_e        alu_op;
    logic           alu_ci;
    logic [W-1:0]   b_op;
    logic [W:0]     sum;
    logic [W-1:0]   alu_r;
    logic           alu_c;
    logic           alu_v;
    logic [7:0]     flags;
    logic [2*W-1:0] alu_res;

    // NOTE: every always_comb output gets a default before the case, so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        alu_op  = alu_op_e'(cmd_q[CMD_OP_MSB:CMD_OP_LSB]);
        alu_ci  = cmd_q[CMD_CI_BIT];
        b_op    = (alu_op == OP_SUB) ? ~rb_q : rb_q;
        sum     = {1'b0, ra_q} + {1'b0, b_op} + {{W{1'b0}}, alu_ci};
        alu_r   = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        unique case (alu_op)
            OP_ADD, OP_SUB: begin
                alu_r = sum[W-1:0];
                alu_c = sum[W];
                alu_v = (ra_q[W-1] == b_op[W-1]) && (alu_r[W-1] != ra_q[W-1]);
            end
            OP_AND:  alu_r = ra_q & rb_q;
            OP_OR:   alu_r = ra_q | rb_q;
            OP_XOR:  alu_r = ra_q ^ rb_q;
            OP_PASS: alu_r = ra_q;
            OP_SHR: begin
                alu_r = {alu_ci, ra_q[W-1:1]};
                alu_c = ra_q[0];
            end
            OP_SHL: begin
                alu_r = {ra_q[W-2:0], alu_ci};
                alu_c = ra_q[W-1];
            end
            default: ;
        endcase
        flags         = 8'h00;
        flags[FLAG_C] = alu_c;
        flags[FLAG_V] = alu_v;
        flags[FLAG_Z] = (alu_r == '0);
        flags[FLAG_N] = alu_r[W-1];
        alu_res         = '0;
        alu_res[W-1:0]  = alu_r;
        alu_res[W +: 8] = flags;
    end

    // Controller with registered bus outputs; the result register is shifted
    // down one byte per OUT cycle so ACC always takes the low byte.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            ra_q        <= '0;
            rb_q        <= '0;
            cmd_q       <= '0;
            res_q       <= '0;
            cnt_q       <= '0;
            len_q       <= '0;
            acc_q       <= '0;
            valid_q     <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            mul_start_q <= 1'b0;
        end else begin
            mul_start_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (bus.LoadCmd_i) begin
                        cmd_q  <= bus.ABCmd_i;
                        busy_q <= 1'b1;
                        cnt_q  <= '0;
                        if (bus.ABCmd_i[CMD_MUL_BIT]) begin
                            state_q     <= ST_MUL;
                            mul_start_q <= 1'b1;
                        end else begin
                            state_q <= ST_EXEC;
                        end
                    end else if (bus.LoadB_i) begin
                        rb_q <= {bus.ABCmd_i, rb_q[W-1:8]};
                    end else if (bus.LoadA_i) begin
                        ra_q <= {bus.ABCmd_i, ra_q[W-1:8]};
                    end
                end
                ST_EXEC: begin
                    res_q   <= alu_res;
                    len_q   <= LEN_ALU;
                    state_q <= ST_OUT;
                end
                ST_MUL: begin
                    if (mul_done) begin
                        res_q   <= mul_p;
                        len_q   <= LEN_MUL;
                        state_q <= ST_OUT;
                    end
                end
                ST_OUT: begin
                    if (cnt_q == len_q) begin
                        acc_q   <= '0;
                        valid_q <= 1'b0;
                        done_q  <= 1'b0;
                        busy_q  <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= ST_IDLE;
                    end else begin
                        acc_q   <= res_q[7:0];
                        res_q   <= res_q >> 8;
                        valid_q <= 1'b1;
                        done_q  <= (cnt_q + 1'b1 == len_q);
                        cnt_q   <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.ACC_o   = acc_q;
    assign bus.Valid_o = valid_q;
    assign bus.Done_o  = done_q;
    assign bus.Busy_o  = busy_q;

endmodule

// File: tb/tb_alu_mult_serial.sv
// Scoreboard bench for alu_mult_serial (W=16): expected bytes are queued from a
// reference model when a command is issued and compared as Valid_o bytes arrive.
module tb_alu_mult_serial;

    localparam int W  = 16;
    localparam int NB = W / 8;

    typedef struct {
        logic [7:0] data;
        logic       last;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   t_cmd;
    int   n_tests;
    int   n_fail;
    exp_t exp_q[$];

    logic [W-1:0] a_m;
    logic [W-1:0] b_m;

    alu_mult_serial_if bus ();

    alu_mult_serial #(.W(W)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Output monitor: every valid byte must match the head of the scoreboard.
    always @(negedge clk) begin
        if (bus.Valid_o) begin
            if (exp_q.size() == 0) begin
                check("unexpected_valid", 32'(bus.ACC_o), 32'hDEAD);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("acc_byte", 32'(bus.ACC_o), 32'(e.data));
                check("done_flag", 32'(bus.Done_o), 32'(e.last));
            end
        end else if (bus.Done_o) begin
            check("done_without_valid", 32'(bus.Done_o), 32'd0);
        end
    end

    // Reference model, written from the arithmetic definitions rather than the datapath.
    task automatic push_expected(input logic [7:0] cmd, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        if (cmd[7]) begin
            logic [2*W-1:0] p;
            p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
            for (int i = 0; i < 2 * NB; i++) begin
                e.data = p[8*i +: 8];
                e.last = (i == 2 * NB - 1);
                exp_q.push_back(e);
            end
        end else begin
            longint       s;
            longint       sv;
            longint       sa;
            longint       sb;
            logic [W-1:0] r;
            logic         c;
            logic         v;
            logic         ci;
            logic [7:0]   fl;
            ci = cmd[3];
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            c  = 1'b0;
            v  = 1'b0;
            r  = '0;
            case (cmd[2:0])
                3'd0: begin
                    s  = longint'(a) + longint'(b) + longint'(ci);
                    sv = sa + sb + longint'(ci);
                    r  = s[W-1:0];
                    c  = s[W];
                    v  = (sv > 32767) || (sv < -32768);
                end
                3'd1: begin
                    s  = longint'(a) + (65535 - longint'(b)) + longint'(ci);
                    sv = sa - sb - 1 + longint'(ci);
                    r  = s[W-1:0];
                    c  = s[W];
                    v  = (sv > 32767) || (sv < -32768);
                end
                3'd2: r = a & b;
                3'd3: r = a | b;
                3'd4: r = a ^ b;
                3'd5: r = a;
                3'd6: begin
                    r = (a >> 1) | ({{(W-1){1'b0}}, ci} << (W - 1));
                    c = a[0];
                end
                default: begin
                    r = (a << 1) | {{(W-1){1'b0}}, ci};
                    c = a[W-1];
                end
            endcase
            fl = {4'b0000, c, v, (r == 0), r[W-1]};
            for (int i = 0; i < NB; i++) begin
                e.data = r[8*i +: 8];
                e.last = 1'b0;
                exp_q.push_back(e);
            end
            e.data = fl;
            e.last = 1'b1;
            exp_q.push_back(e);
        end
    endtask

    task automatic load_a(input logic [W-1:0] v);
        for (int i = 0; i < NB; i++) begin
            bus.ABCmd_i = v[8*i +: 8];
            bus.LoadA_i = 1'b1;
            @(negedge clk);
        end
        bus.LoadA_i = 1'b0;
        a_m = v;
    endtask

    task automatic load_b(input logic [W-1:0] v);
        for (int i = 0; i < NB; i++) begin
            bus.ABCmd_i = v[8*i +: 8];
            bus.LoadB_i = 1'b1;
            @(negedge clk);
        end
        bus.LoadB_i = 1'b0;
        b_m = v;
    endtask

    // Drives one command byte; with also_a the LoadA strobe is raised alongside it.
    task automatic issue_cmd(input logic [7:0] cmd, input logic also_a);
        push_expected(cmd, a_m, b_m);
        bus.ABCmd_i   = cmd;
        bus.LoadCmd_i = 1'b1;
        bus.LoadA_i   = also_a;
        t_cmd = cyc + 1;
        @(negedge clk);
        bus.LoadCmd_i = 1'b0;
        bus.LoadA_i   = 1'b0;
    endtask

    // Returns on the negedge where Done_o is seen.
    task automatic wait_result(input string tag, input int lat);
        int n;
        n = 0;
        while (!bus.Valid_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus.Valid_o) begin
            check({tag, "_timeout_valid"}, 32'd0, 32'd1);
            return;
        end
        check({tag, "_latency"}, 32'(cyc - t_cmd), 32'(lat));
        while (!bus.Done_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus.Done_o) check({tag, "_timeout_done"}, 32'd0, 32'd1);
    endtask

    task automatic run(input string tag, input logic [7:0] cmd, input int lat);
        issue_cmd(cmd, 1'b0);
        wait_result(tag, lat);
        @(negedge clk);
        check({tag, "_busy_after"}, 32'(bus.Busy_o), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests       = 0;
        n_fail        = 0;
        cyc           = 0;
        t_cmd         = 0;
        a_m           = '0;
        b_m           = '0;
        rst_n         = 1'b0;
        bus.ABCmd_i   = 8'h00;
        bus.LoadA_i   = 1'b0;
        bus.LoadB_i   = 1'b0;
        bus.LoadCmd_i = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_busy",  32'(bus.Busy_o),  32'd0);
        check("reset_valid", 32'(bus.Valid_o), 32'd0);
        check("reset_done",  32'(bus.Done_o),  32'd0);
        check("reset_acc",   32'(bus.ACC_o),   32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // ADD: 0x1234 + 0x0FF0 -> 24 22 00
        load_a(16'h1234);
        load_b(16'h0FF0);
        issue_cmd(8'h00, 1'b0);
        check("add_busy", 32'(bus.Busy_o), 32'd1);
        wait_result("add", 2);
        @(negedge clk);

        // MUL: 0xFFFF * 0xFFFF -> 01 00 FE FF
        load_a(16'hFFFF);
        load_b(16'hFFFF);
        run("mul", 8'h80, W + 2);

        // SUB with carry-in: 5 - 5 -> 00 00 0A
        load_a(16'h0005);
        load_b(16'h0005);
        run("sub", 8'h09, 2);

        // Signed overflow: 0x7FFF + 1 -> 00 80 05
        load_a(16'h7FFF);
        load_b(16'h0001);
        run("ovf", 8'h00, 2);

        // Loads during a multiply are ignored; back-to-back PASS shows A intact
        issue_cmd(8'h80, 1'b0);
        bus.ABCmd_i = 8'hAA;
        bus.LoadA_i = 1'b1;
        repeat (3) @(negedge clk);
        bus.LoadA_i = 1'b0;
        check("mul_busy", 32'(bus.Busy_o), 32'd1);
        wait_result("mul_ignore", W + 2);
        @(negedge clk);
        check("b2b_busy", 32'(bus.Busy_o), 32'd0);
        issue_cmd(8'h05, 1'b0);
        wait_result("b2b_pass", 2);
        @(negedge clk);

        // Reset in the middle of a multiply
        issue_cmd(8'h80, 1'b0);
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_busy",  32'(bus.Busy_o),  32'd0);
        check("midrst_valid", 32'(bus.Valid_o), 32'd0);
        check("midrst_done",  32'(bus.Done_o),  32'd0);
        check("midrst_acc",   32'(bus.ACC_o),   32'd0);
        exp_q.delete();
        a_m   = '0;
        b_m   = '0;
        rst_n = 1'b1;
        repeat (W + 8) @(negedge clk);
        run("rst_pass_a", 8'h05, 2);
        run("rst_or_b", 8'h03, 2);

        // LoadCmd beats LoadA in the same cycle
        load_a(16'hBEEF);
        load_b(16'h1357);
        issue_cmd(8'h05, 1'b1);
        wait_result("prio_cmd", 2);
        @(negedge clk);
        run("prio_pass", 8'h05, 2);

        // LoadB beats LoadA in the same cycle
        bus.LoadA_i = 1'b1;
        bus.LoadB_i = 1'b1;
        bus.ABCmd_i = 8'h11;
        @(negedge clk);
        bus.ABCmd_i = 8'h22;
        @(negedge clk);
        bus.LoadA_i = 1'b0;
        bus.LoadB_i = 1'b0;
        b_m = 16'h2211;
        run("prio_ab_xor", 8'h04, 2);

        // Remaining ops on random operands, both carry-in values
        for (int k = 0; k < 12; k++) begin
            logic [7:0] cmd;
            load_a(W'($urandom));
            load_b(W'($urandom));
            cmd = {4'b0000, k[0], 3'(k % 8)};
            run("rand_op", cmd, 2);
        end
        load_a(W'($urandom));
        load_b(W'($urandom));
        run("rand_mul", 8'hF8, W + 2);

        repeat (4) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
